// File: rtl/reset_request_ctrl.sv
// Run-time soft-reset sequencer for the display datapath: LCD -> read FIFO -> SDRAM down, then back up in reverse.
// Optional bounded waits on frame end / read idle are enabled with `define RESET_REQ_TIMEOUT_EN.
module reset_request_ctrl #(
  parameter int HOLD_CYC    = 1024,
  parameter int GAP_CYC     = 256,
  parameter int TIMEOUT_CYC = 1048576,
  parameter int CW          = 21
) (
  input  logic iCLK,
  input  logic iRSTN,
  input  logic iREQ,
  input  logic iFRAME_END,
  input  logic iRD_IDLE,
  output logic oRSTN,
  output logic oRD_RST,
  output logic oRST,
  output logic oBUSY,
  output logic oDONE,
  output logic oTIMEOUT
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] WAIT_FRAME = 3'd1;
  localparam logic [2:0] WAIT_RD    = 3'd2;
  localparam logic [2:0] DRAIN      = 3'd3;
  localparam logic [2:0] HOLD       = 3'd4;
  localparam logic [2:0] REL_RD     = 3'd5;
  localparam logic [2:0] REL_LCD    = 3'd6;

`ifdef RESET_REQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYC - 1);

  logic [2:0]    state, stateNxt;
  logic [CW-1:0] cnt, cntNxt;
  logic          pending, pendNxt;
  logic          rstnNxt, rdRstNxt, rstNxt, doneNxt, toNxt;

  // Request synchroniser. History is only fed from the chain once the chain
  // holds real samples, so a request held high across reset never fires.
  logic       reqS1, reqS2, reqHist;
  logic [1:0] syncPrimed;
  logic       reqEdge;

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      reqS1      <= 1'b0;
      reqS2      <= 1'b0;
      reqHist    <= 1'b1;
      syncPrimed <= 2'b00;
    end else begin
      reqS1      <= iREQ;
      reqS2      <= reqS1;
      syncPrimed <= {syncPrimed[0], 1'b1};
      reqHist    <= syncPrimed[1] ? reqS2 : 1'b1;
    end
  end

  assign reqEdge = reqS2 & ~reqHist;

  logic waitExpired;
  assign waitExpired = TO_EN && (cnt == TO_LAST);

  always_comb begin
    stateNxt = state;
    cntNxt   = cnt + CW'(1);
    pendNxt  = pending | (reqEdge && (state != IDLE));
    rstnNxt  = oRSTN;
    rdRstNxt = oRD_RST;
    rstNxt   = oRST;
    doneNxt  = 1'b0;
    toNxt    = oTIMEOUT;
    case (state)
      IDLE: begin
        cntNxt = '0;
        if (reqEdge || pending) begin
          stateNxt = WAIT_FRAME;
          pendNxt  = 1'b0;
          toNxt    = 1'b0;
        end
      end
      WAIT_FRAME: begin
        if (!TO_EN) cntNxt = '0;
        if (iFRAME_END || waitExpired) begin
          stateNxt = WAIT_RD;
          cntNxt   = '0;
          rstNxt   = 1'b1;
          if (!iFRAME_END) toNxt = 1'b1;
        end
      end
      WAIT_RD: begin
        if (!TO_EN) cntNxt = '0;
        if (iRD_IDLE || waitExpired) begin
          stateNxt = DRAIN;
          cntNxt   = '0;
          rdRstNxt = 1'b1;
          if (!iRD_IDLE) toNxt = 1'b1;
        end
      end
      DRAIN: begin
        if (cnt == GAP_LAST) begin
          stateNxt = HOLD;
          cntNxt   = '0;
          rstnNxt  = 1'b0;
        end
      end
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          stateNxt = REL_RD;
          cntNxt   = '0;
          rstnNxt  = 1'b1;
        end
      end
      REL_RD: begin
        if (cnt == GAP_LAST) begin
          stateNxt = REL_LCD;
          cntNxt   = '0;
          rdRstNxt = 1'b0;
        end
      end
      REL_LCD: begin
        if (cnt == GAP_LAST) begin
          stateNxt = IDLE;
          cntNxt   = '0;
          rstNxt   = 1'b0;
          doneNxt  = 1'b1;
        end
      end
      default: begin
        stateNxt = IDLE;
        cntNxt   = '0;
      end
    endcase
  end

  // Reset lands in HOLD with everything asserted, so power-up runs the release half.
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      state    <= HOLD;
      cnt      <= '0;
      pending  <= 1'b0;
      oRSTN    <= 1'b0;
      oRD_RST  <= 1'b1;
      oRST     <= 1'b1;
      oBUSY    <= 1'b1;
      oDONE    <= 1'b0;
      oTIMEOUT <= 1'b0;
    end else begin
      state    <= stateNxt;
      cnt      <= cntNxt;
      pending  <= pendNxt;
      oRSTN    <= rstnNxt;
      oRD_RST  <= rdRstNxt;
      oRST     <= rstNxt;
      oBUSY    <= (stateNxt != IDLE);
      oDONE    <= doneNxt;
      oTIMEOUT <= toNxt;
    end
  end

endmodule

// File: tb/tb_reset_request_ctrl.sv
// Scoreboard bench for reset_request_ctrl: expected output changes {cycle, value} are queued by the
// stimulus; a monitor pops one entry on every observed change of the output vector.
module tb_reset_request_ctrl;

  logic iCLK, iRSTN, iREQ, iFRAME_END, iRD_IDLE;
  logic oRSTN, oRD_RST, oRST, oBUSY, oDONE, oTIMEOUT;

  reset_request_ctrl #(
    .HOLD_CYC(8), .GAP_CYC(4), .TIMEOUT_CYC(32), .CW(21)
  ) dut (
    .iCLK(iCLK), .iRSTN(iRSTN), .iREQ(iREQ), .iFRAME_END(iFRAME_END), .iRD_IDLE(iRD_IDLE),
    .oRSTN(oRSTN), .oRD_RST(oRD_RST), .oRST(oRST), .oBUSY(oBUSY), .oDONE(oDONE),
    .oTIMEOUT(oTIMEOUT)
  );

  typedef struct {
    int         cyc;
    logic [5:0] val;   // {oRSTN, oRD_RST, oRST, oBUSY, oDONE, oTIMEOUT}
  } expT;

  expT expQ[$];
  int  cyc = 0;
  int  nVec = 0;
  int  nBad = 0;
  bit  finishing = 1'b0;
  bit  monDone = 1'b0;

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;
  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic waitTo(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push(input int c, input logic [5:0] v);
    expT e;
    e.cyc = c;
    e.val = v;
    expQ.push_back(e);
  endtask

  // Frame taken at f: oRST up.
  task automatic pushFrame(input int f, input logic to);
    push(f, {5'b10110, to});
  endtask

  // Read idle taken at r: rest of shutdown and full release, ending in the oDONE cycle.
  task automatic pushRel(input int r, input logic to);
    push(r,      {5'b11110, to});
    push(r + 4,  {5'b01110, to});
    push(r + 12, {5'b11110, to});
    push(r + 16, {5'b10110, to});
    push(r + 20, {5'b10001, to});
  endtask

  // Power-up release from reset deasserted after cycle r.
  task automatic pushPowerUp(input int r);
    push(r + 8,  6'b111100);
    push(r + 12, 6'b101100);
    push(r + 16, 6'b100010);
    push(r + 17, 6'b100000);
  endtask

  task automatic pulseReq(input int at);
    waitTo(at);
    iREQ = 1'b1;
    waitTo(at + 2);
    iREQ = 1'b0;
  endtask

  task automatic pulseFrame(input int at);
    waitTo(at);
    iFRAME_END = 1'b1;
    waitTo(at + 1);
    iFRAME_END = 1'b0;
  endtask

  // Monitor: one comparison per change of the output vector.
  initial begin
    logic [5:0] prev, cur;
    expT e;
    prev = 'x;
    forever begin
      @(negedge iCLK);
      if (finishing) break;
      cur = {oRSTN, oRD_RST, oRST, oBUSY, oDONE, oTIMEOUT};
      if (cur !== prev) begin
        nVec++;
        if (expQ.size() == 0) begin
          nBad++;
          $display("FAIL unexpected_change: got %b at cyc %0d, no change expected", cur, cyc);
        end else begin
          e = expQ.pop_front();
          if (e.cyc != cyc || e.val !== cur) begin
            nBad++;
            $display("FAIL step: got %b at cyc %0d, expected %b at cyc %0d", cur, cyc, e.val, e.cyc);
          end
        end
        prev = cur;
      end
    end
    nVec++;
    if (expQ.size() != 0) begin
      nBad++;
      $display("FAIL leftover: %0d expected changes never seen, next %b at cyc %0d, required 0 left",
               expQ.size(), expQ[0].val, expQ[0].cyc);
    end
    monDone = 1'b1;
  end

  initial begin
    iRSTN = 1'b0; iREQ = 1'b0; iFRAME_END = 1'b0; iRD_IDLE = 1'b1;

    // Power-up
    push(1, 6'b011100);
    waitTo(5);
    iRSTN = 1'b1;
    pushPowerUp(5);

    // Request held high across reset must not start a sequence
    waitTo(30);
    iRSTN = 1'b0;
    iREQ  = 1'b1;
    push(30, 6'b011100);
    waitTo(33);
    iRSTN = 1'b1;
    pushPowerUp(33);
    waitTo(65);
    iREQ = 1'b0;

    // Normal request, frame end 10 cycles later, read path idle
    push(73, 6'b100100);
    pulseReq(70);
    pushFrame(81, 1'b0);
    pushRel(82, 1'b0);
    push(103, 6'b100000);
    pulseFrame(80);

    // Pending request from HOLD restarts immediately; a third edge in REL_RD is dropped
    push(113, 6'b100100);
    pulseReq(110);
    pushFrame(115, 1'b0);
    pushRel(116, 1'b0);
    push(137, 6'b100100);
    pulseFrame(114);
    pulseReq(121);
    pulseReq(126);
    pushFrame(141, 1'b0);
    pushRel(142, 1'b0);
    push(163, 6'b100000);
    pulseFrame(140);
    waitTo(180);

    // Read path stuck busy
    iRD_IDLE = 1'b0;
    push(185, 6'b100100);
    pulseReq(182);
    pushFrame(187, 1'b0);
    pulseFrame(186);
`ifdef RESET_REQ_TIMEOUT_EN
    pushRel(219, 1'b1);
    push(240, 6'b100001);
    waitTo(245);
    iRD_IDLE = 1'b1;
    push(253, 6'b100100);
    pulseReq(250);
    pushFrame(255, 1'b0);
    pushRel(256, 1'b0);
    push(277, 6'b100000);
    pulseFrame(254);
`else
    waitTo(240);
    iRD_IDLE = 1'b1;
    pushRel(241, 1'b0);
    push(262, 6'b100000);
`endif
    waitTo(280);

    // Reset during REL_RD with a request pending: release restarts, pending is lost
    push(283, 6'b100100);
    pulseReq(280);
    pushFrame(285, 1'b0);
    push(286, 6'b111100);
    push(290, 6'b011100);
    push(298, 6'b111100);
    pulseFrame(284);
    pulseReq(291);
    waitTo(299);
    iRSTN = 1'b0;
    push(299, 6'b011100);
    waitTo(300);
    iRSTN = 1'b1;
    pushPowerUp(300);
    waitTo(340);

    finishing = 1'b1;
    waitTo(345);
    if (!monDone) begin
      $display("FAIL monitor_stuck: monitor did not finish, required finished");
      $fatal(1, "monitor did not terminate");
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule

// File: doc/reset_request_ctrl.md
Name: reset_request_ctrl

Overview:
- Run-time soft-reset controller for the display datapath.
- On a user or system request, shuts the datapath down in order: LCD timing first, then the SDRAM read FIFO, then the SDRAM controller.
- Holds that state, then releases the resets in the reverse order.
- Sits between key debounce / host logic and the SDRAM controller, read FIFO and LCD timing blocks; drives the same three reset nets they already use.

Parameters:
HOLD_CYC, 1024, cycles oRSTN stays low in HOLD
GAP_CYC, 256, cycles between consecutive assert/release steps
TIMEOUT_CYC, 1048576, max wait cycles in WAIT_FRAME / WAIT_RD (used only with timeout feature)
CW, 21, counter width; must satisfy 2^CW > max(HOLD_CYC, GAP_CYC, TIMEOUT_CYC)

Ports:
iCLK  in  1  system clock
iRSTN  in  1  reset, asynchronous, active-low
iREQ  in  1  soft-reset request, asynchronous level; rising edge triggers
iFRAME_END  in  1  one-cycle pulse from LCD timing at end of active frame
iRD_IDLE  in  1  read path idle, no SDRAM read burst outstanding
oRSTN  out  1  SDRAM controller reset, active-low
oRD_RST  out  1  read FIFO reset, active-high
oRST  out  1  LCD / display reset, active-high
oBUSY  out  1  high whenever state != IDLE
oDONE  out  1  one-cycle pulse when a sequence completes
oTIMEOUT  out  1  sticky flag, a wait was abandoned by timeout

Behaviour:
- Async reset (iRSTN=0): state=HOLD, cnt=0, oRSTN=0, oRD_RST=1, oRST=1, oBUSY=1, oDONE=0, oTIMEOUT=0, pending=0.
- Async reset, synchroniser: request synchroniser FFs reset to 0; edge-detect history register resets to 1, so a request held high through reset does not trigger.
- After iRSTN rises, the block runs the release half of the sequence (power-up path).
- Request path: iREQ → 2-FF synchroniser → rising-edge detect. Edge visible 3 iCLK after iREQ rises.
- Edge in IDLE: go to WAIT_FRAME.
- Edge while not IDLE: sets pending (one deep; further edges are lost).
- IDLE with pending=1: clears pending and enters WAIT_FRAME next cycle.
- Single counter cnt (CW bits): cleared on every state entry, increments each cycle in timed states. A timed state of N cycles exits when cnt==N-1.
- All outputs are registered; each output changes on the same edge as the transition into its state.
- IDLE: oRSTN=1, oRD_RST=0, oRST=0, oBUSY=0.
- WAIT_FRAME: waits for iFRAME_END=1. On it: oRST←1, go WAIT_RD.
- WAIT_RD: waits for iRD_IDLE=1 (may already be high: 1-cycle dwell). On it: oRD_RST←1, go DRAIN.
- DRAIN: GAP_CYC cycles, then oRSTN←0, go HOLD.
- HOLD: HOLD_CYC cycles, then oRSTN←1, go REL_RD.
- REL_RD: GAP_CYC cycles, then oRD_RST←0, go REL_LCD.
- REL_LCD: GAP_CYC cycles, then oRST←0, oDONE←1 for one cycle, go IDLE.
- Output ordering invariant, never violated:
  - oRST asserted before oRD_RST, oRD_RST before oRSTN low.
  - Release order is exactly reversed.
- Simultaneous iFRAME_END and request edge in WAIT_FRAME: the frame event is taken; the edge sets pending.
- iRSTN low mid-sequence: immediate async jump to the reset state above; any pending request is discarded.
- Counter never wraps: the state exits at the terminal count first.

Optional Feature:
RESET_REQ_TIMEOUT_EN
- Defined:
  - In WAIT_FRAME and WAIT_RD, cnt increments.
  - If cnt==TIMEOUT_CYC-1 before the awaited event, the block proceeds exactly as if the event occurred and sets oTIMEOUT=1.
  - oTIMEOUT clears when the next request edge is accepted from IDLE, or on reset.
- Undefined:
  - Waits are unbounded; cnt is held at 0 in the wait states.
  - oTIMEOUT is constant 0.

Test Plan:
Params HOLD_CYC=8, GAP_CYC=4, TIMEOUT_CYC=32 for all scenarios.
1. Power-up: iRSTN low 5 cycles then high → oRSTN=0/oRD_RST=1/oRST=1 during reset; oRSTN rises 8 cycles after release, oRD_RST falls 4 later, oRST falls 4 later with oDONE pulse; oBUSY=0 afterward.
2. Held request through reset: iREQ=1 throughout reset and after → no sequence after power-up; oBUSY stays 0 once IDLE.
3. Normal request: iREQ pulse, iFRAME_END 10 cycles later, iRD_IDLE=1 → oRST=1 on frame edge, oRD_RST=1 next cycle, oRSTN=0 4 cycles later; release after 8/4/4 cycles, single oDONE.
4. Request during HOLD → pending set; a second full sequence starts immediately after oDONE with no new iREQ edge; third edge in same window is dropped.
5. iRD_IDLE=0 stuck, feature on → 32 cycles in WAIT_RD then proceeds, oTIMEOUT=1 until next accepted request; feature off → remains in WAIT_RD, oBUSY=1 indefinitely.
6. iRSTN pulsed low during REL_RD → outputs immediately 0/1/1, pending cleared, release sequence restarts from HOLD.
